// File: rtl/shot_responder.sv
// Battleship shot responder: holds this side's board, accepts opponent shots,
// and answers hit / repeat / off-board until every ship cell has been sunk.
module shot_responder #(
    parameter int BOARD_N    = 10,
    parameter int SHIP_CELLS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       place_en,
    input  logic [7:0] place_pos,
    input  logic       arm,
    input  logic       shot_valid,
    input  logic [7:0] shot_pos,
    output logic       shot_ready,
    output logic       answer_valid,
    output logic       answer_hit,
    output logic       answer_repeat,
    output logic       answer_bad,
    input  logic       answer_ack,
    output logic       my_turn,
    output logic [6:0] placed_cnt,
    output logic [6:0] cells_left,
    output logic       all_sunk,
    output logic [3:0] state_led
);

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IW    = $clog2(CELLS);

    typedef enum logic [2:0] {PLACE, ARMED, LOOKUP, RESPOND, DEFEAT} state_t;

    state_t           state;
    logic [CELLS-1:0] ship_map;
    logic [CELLS-1:0] shot_map;
    logic [7:0]       shot_cap;
    logic             fresh_miss;

    logic [IW-1:0]    place_idx;
    logic [IW-1:0]    shot_idx;
    logic             place_ok;
    logic             shot_in;

    function automatic logic in_board(input logic [7:0] pos);
        return (int'(pos[7:4]) < BOARD_N) && (int'(pos[3:0]) < BOARD_N);
    endfunction

    function automatic logic [IW-1:0] cell_index(input logic [7:0] pos);
        return IW'(int'(pos[7:4]) * BOARD_N + int'(pos[3:0]));
    endfunction

    // Off-board coordinates produce a meaningless index; in_board gates every use.
    assign place_idx = cell_index(place_pos);
    assign place_ok  = in_board(place_pos) && !ship_map[place_idx];
    assign shot_idx  = cell_index(shot_cap);
    assign shot_in   = in_board(shot_cap);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= PLACE;
            ship_map      <= '0;
            shot_map      <= '0;
            shot_cap      <= '0;
            placed_cnt    <= '0;
            cells_left    <= '0;
            answer_valid  <= 1'b0;
            answer_hit    <= 1'b0;
            answer_repeat <= 1'b0;
            answer_bad    <= 1'b0;
            fresh_miss    <= 1'b0;
        end else begin
            case (state)
                PLACE: begin
                    if (place_en && place_ok) begin
                        ship_map[place_idx] <= 1'b1;
                        placed_cnt          <= placed_cnt + 7'd1;
                    end
                    // Compares the count before any same-cycle placement lands.
                    if (arm && placed_cnt == 7'(SHIP_CELLS)) begin
                        state      <= ARMED;
                        cells_left <= 7'(SHIP_CELLS);
                    end
                end
                ARMED: begin
                    if (shot_valid) begin
                        shot_cap <= shot_pos;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    answer_valid  <= 1'b1;
                    answer_hit    <= 1'b0;
                    answer_repeat <= 1'b0;
                    answer_bad    <= 1'b0;
                    fresh_miss    <= 1'b0;
                    if (!shot_in) begin
                        answer_bad <= 1'b1;
                    end else if (shot_map[shot_idx]) begin
                        answer_repeat <= 1'b1;
                        answer_hit    <= ship_map[shot_idx];
                    end else begin
                        shot_map[shot_idx] <= 1'b1;
                        answer_hit         <= ship_map[shot_idx];
                        fresh_miss         <= !ship_map[shot_idx];
                        if (ship_map[shot_idx] && cells_left != 7'd0)
                            cells_left <= cells_left - 7'd1;
                    end
                    state <= RESPOND;
                end
                RESPOND: begin
                    if (answer_ack) begin
                        answer_valid  <= 1'b0;
                        answer_hit    <= 1'b0;
                        answer_repeat <= 1'b0;
                        answer_bad    <= 1'b0;
                        fresh_miss    <= 1'b0;
                        state         <= (cells_left == 7'd0) ? DEFEAT : ARMED;
                    end
                end
                DEFEAT: begin
                    state <= DEFEAT;
                end
                default: state <= PLACE;
            endcase
        end
    end

    assign shot_ready = (state == ARMED);
    assign all_sunk   = (state == DEFEAT);
    assign my_turn    = (state == RESPOND) && answer_ack && fresh_miss;

    always_comb begin
        state_led = 4'b0001;
        case (state)
            PLACE:           state_led = 4'b0001;
            ARMED:           state_led = 4'b0010;
            LOOKUP, RESPOND: state_led = 4'b0100;
            DEFEAT:          state_led = 4'b1000;
            default:         state_led = 4'b0001;
        endcase
    end

endmodule
